// File: rtl/dbus_pkg.sv
// Shared types and constants for the two-master data-bus arbiter.
package dbus_pkg;

   localparam int unsigned BUS_W = 16;

   localparam logic M_CPU = 1'b0;
   localparam logic M_EXT = 1'b1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

endpackage

// File: rtl/dbus_arbiter_rr_pick.sv
// Two-way round-robin selector: on a tie, the requester not served last wins.
module dbus_rr_pick (
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic       o_grant_c,
   output logic       o_valid_c
);

   always_comb begin
      o_valid_c = |i_req;
      o_grant_c = i_req[1];
      if (&i_req) o_grant_c = ~i_last;
   end

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master, one-slave bus arbiter with round-robin grant and a bus-timeout watchdog.
module dbus_arbiter
   import dbus_pkg::*;
#(
   parameter int unsigned TIMEOUT  = 64,
   parameter int unsigned TMO_W    = 8,
   parameter int unsigned M0_FIRST = 1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [BUS_W-1:0] i_m0_addr,
   input  logic [BUS_W-1:0] i_m0_dat,
   input  logic             i_m0_we,
   input  logic             i_m0_cs,
   output logic [BUS_W-1:0] o_m0_dat,
   output logic             o_m0_ack,
   input  logic [BUS_W-1:0] i_m1_addr,
   input  logic [BUS_W-1:0] i_m1_dat,
   input  logic             i_m1_we,
   input  logic             i_m1_cs,
   output logic [BUS_W-1:0] o_m1_dat,
   output logic             o_m1_ack,
   output logic [BUS_W-1:0] o_s_addr,
   output logic [BUS_W-1:0] o_s_dat,
   output logic             o_s_we,
   output logic             o_s_cs,
   input  logic [BUS_W-1:0] i_s_dat,
   input  logic             i_s_ack,
   output logic             o_err,
   output logic             o_grant
);

   localparam int unsigned TMO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

   state_e           state_q, state_d;
   logic             grant_q, grant_d;
   logic             last_q,  last_d;
   logic [TMO_W-1:0] cnt_q,   cnt_d;

   logic             pick_grant, pick_valid;
   logic             own_cs, own_we;
   logic [BUS_W-1:0] own_addr, own_dat;
   logic             tmo_hit;
   logic             ack;
   logic [BUS_W-1:0] rdat;

   dbus_rr_pick u_pick (
      .i_req     ({i_m1_cs, i_m0_cs}),
      .i_last    (last_q),
      .o_grant_c (pick_grant),
      .o_valid_c (pick_valid)
   );

   // Signals of whichever master currently owns the bus.
   always_comb begin
      own_cs   = (grant_q == M_EXT) ? i_m1_cs   : i_m0_cs;
      own_we   = (grant_q == M_EXT) ? i_m1_we   : i_m0_we;
      own_addr = (grant_q == M_EXT) ? i_m1_addr : i_m0_addr;
      own_dat  = (grant_q == M_EXT) ? i_m1_dat  : i_m0_dat;
      tmo_hit  = (TIMEOUT != 0) && (cnt_q == TMO_W'(TMO_LAST));
   end

   // Next-state and bus outputs; abort beats ack, and a real ack beats the watchdog.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      cnt_d    = cnt_q;
      o_s_addr = '0;
      o_s_dat  = '0;
      o_s_we   = 1'b0;
      o_s_cs   = 1'b0;
      o_err    = 1'b0;
      ack      = 1'b0;
      rdat     = i_s_dat;
      case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               state_d = ST_BUSY;
               grant_d = pick_grant;
               cnt_d   = '0;
            end
         end
         ST_BUSY: begin
            o_s_addr = own_addr;
            o_s_dat  = own_dat;
            o_s_we   = own_we;
            o_s_cs   = own_cs;
            if (!own_cs) begin
               state_d = ST_IDLE;
            end else if (i_s_ack) begin
               ack     = 1'b1;
               last_d  = grant_q;
               state_d = ST_IDLE;
            end else if (tmo_hit) begin
               ack     = 1'b1;
               o_err   = 1'b1;
               rdat    = '0;
               o_s_cs  = 1'b0;
               last_d  = grant_q;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + TMO_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      o_m0_ack = ack && (grant_q == M_CPU);
      o_m1_ack = ack && (grant_q == M_EXT);
      o_m0_dat = rdat;
      o_m1_dat = rdat;
      o_grant  = grant_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= ST_IDLE;
         grant_q <= M_CPU;
         last_q  <= (M0_FIRST != 0) ? M_EXT : M_CPU;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Self-checking bench for dbus_arbiter: directed scenarios plus randomized traffic against a transaction model.
module tb_dbus_arbiter;

   localparam int unsigned TMO = 4;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic [15:0] i_m0_addr, i_m0_dat, i_m1_addr, i_m1_dat, i_s_dat;
   logic        i_m0_we, i_m0_cs, i_m1_we, i_m1_cs, i_s_ack;
   logic [15:0] o_m0_dat, o_m1_dat, o_s_addr, o_s_dat;
   logic        o_m0_ack, o_m1_ack, o_s_we, o_s_cs, o_err, o_grant;

   int total = 0;
   int bad   = 0;

   always #5 i_clk = ~i_clk;

   dbus_arbiter #(.TIMEOUT(TMO), .TMO_W(8), .M0_FIRST(1)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_m0_addr(i_m0_addr), .i_m0_dat(i_m0_dat), .i_m0_we(i_m0_we), .i_m0_cs(i_m0_cs),
      .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack),
      .i_m1_addr(i_m1_addr), .i_m1_dat(i_m1_dat), .i_m1_we(i_m1_we), .i_m1_cs(i_m1_cs),
      .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack),
      .o_s_addr(o_s_addr), .o_s_dat(o_s_dat), .o_s_we(o_s_we), .o_s_cs(o_s_cs),
      .i_s_dat(i_s_dat), .i_s_ack(i_s_ack), .o_err(o_err), .o_grant(o_grant)
   );

   // Transaction model: owner (-1 = bus free), cycles spent waiting, last master served.
   int          m_owner = -1;
   int          m_age   = 0;
   int          m_last  = 1;
   logic        m_cs_own;
   logic [15:0] exp_s_addr, exp_s_dat, exp_rdat;
   logic        exp_s_we, exp_s_cs, exp_ack0, exp_ack1, exp_err, exp_done;

   always_comb begin
      m_cs_own   = 1'b0;
      exp_s_addr = '0;
      exp_s_dat  = '0;
      exp_s_we   = 1'b0;
      exp_rdat   = i_s_dat;
      exp_err    = 1'b0;
      exp_done   = 1'b0;
      if (m_owner == 0) begin
         m_cs_own = i_m0_cs; exp_s_addr = i_m0_addr; exp_s_dat = i_m0_dat; exp_s_we = i_m0_we;
      end else if (m_owner == 1) begin
         m_cs_own = i_m1_cs; exp_s_addr = i_m1_addr; exp_s_dat = i_m1_dat; exp_s_we = i_m1_we;
      end
      if (m_owner >= 0 && m_cs_own) begin
         if (i_s_ack) begin
            exp_done = 1'b1;
         end else if (TMO != 0 && m_age == int'(TMO) - 1) begin
            exp_done = 1'b1;
            exp_err  = 1'b1;
            exp_rdat = '0;
         end
      end
      exp_s_cs = m_cs_own && !exp_err;
      exp_ack0 = exp_done && (m_owner == 0);
      exp_ack1 = exp_done && (m_owner == 1);
   end

   always @(posedge i_clk) begin
      if (i_reset) begin
         m_owner <= -1;
         m_age   <= 0;
         m_last  <= 1;
      end else if (m_owner < 0) begin
         m_age <= 0;
         if (i_m0_cs && i_m1_cs) m_owner <= 1 - m_last;
         else if (i_m0_cs)       m_owner <= 0;
         else if (i_m1_cs)       m_owner <= 1;
      end else if (!m_cs_own) begin
         m_owner <= -1;
      end else if (exp_done) begin
         m_last  <= m_owner;
         m_owner <= -1;
      end else begin
         m_age <= m_age + 1;
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic settle();
      @(negedge i_clk);
   endtask

   task automatic idle_inputs();
      i_m0_cs = 0; i_m0_we = 0; i_m0_addr = '0; i_m0_dat = '0;
      i_m1_cs = 0; i_m1_we = 0; i_m1_addr = '0; i_m1_dat = '0;
      i_s_ack = 0; i_s_dat = '0;
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      idle_inputs();
      tick();
      tick();
      i_reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      settle();
      total++; if (o_s_cs !== 1'b0)   begin bad++; $display("FAIL rst_s_cs got=%0b want=0", o_s_cs); end
      total++; if (o_s_addr !== 16'h0) begin bad++; $display("FAIL rst_s_addr got=%h want=0000", o_s_addr); end
      total++; if ({o_m0_ack, o_m1_ack, o_err, o_s_we} !== 4'b0)
         begin bad++; $display("FAIL rst_flags got=%b want=0000", {o_m0_ack, o_m1_ack, o_err, o_s_we}); end
   endtask

   task automatic test_single_read();
      do_reset();
      i_m0_cs = 1; i_m0_addr = 16'h0010; i_s_dat = 16'hBEEF;
      settle();
      total++; if (o_s_cs !== 1'b0) begin bad++; $display("FAIL rd_latency s_cs got=%0b want=0", o_s_cs); end
      tick(); settle();
      total++; if (o_s_cs !== 1'b1 || o_s_addr !== 16'h0010 || o_grant !== 1'b0)
         begin bad++; $display("FAIL rd_busy cs/addr/grant got=%0b/%h/%0b want=1/0010/0", o_s_cs, o_s_addr, o_grant); end
      tick(); settle();
      total++; if (o_m0_ack !== 1'b0) begin bad++; $display("FAIL rd_early_ack got=%0b want=0", o_m0_ack); end
      tick(); i_s_ack = 1; settle();
      total++; if (o_m0_ack !== 1'b1 || o_m0_dat !== 16'hBEEF || o_m1_ack !== 1'b0)
         begin bad++; $display("FAIL rd_ack ack0/dat/ack1 got=%0b/%h/%0b want=1/beef/0", o_m0_ack, o_m0_dat, o_m1_ack); end
      tick(); i_m0_cs = 0; i_s_ack = 0; settle();
      total++; if (o_s_cs !== 1'b0 || o_m0_ack !== 1'b0)
         begin bad++; $display("FAIL rd_after cs/ack got=%0b/%0b want=0/0", o_s_cs, o_m0_ack); end
   endtask

   task automatic test_round_robin();
      int want_g;
      do_reset();
      i_m0_cs = 1; i_m1_cs = 1; i_m0_addr = 16'h0100; i_m1_addr = 16'h0200;
      i_s_ack = 1; i_s_dat = 16'h1111;
      for (int i = 0; i < 8; i++) begin
         settle();
         total++; if (o_s_cs !== 1'((i % 2)))
            begin bad++; $display("FAIL rr_cs[%0d] got=%0b want=%0d", i, o_s_cs, i % 2); end
         if (i % 2 == 1) begin
            want_g = (i / 2) % 2;
            total++; if (o_grant !== 1'(want_g) || o_m0_ack !== 1'(want_g == 0) || o_m1_ack !== 1'(want_g == 1))
               begin bad++; $display("FAIL rr_order[%0d] grant/ack0/ack1 got=%0b/%0b/%0b want_grant=%0d", i, o_grant, o_m0_ack, o_m1_ack, want_g); end
         end
         tick();
      end
      idle_inputs();
      tick();
   endtask

   task automatic test_write();
      do_reset();
      i_m1_cs = 1; i_m1_we = 1; i_m1_addr = 16'h8000; i_m1_dat = 16'h1234;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (k == 2) i_s_ack = 1;
         settle();
         total++; if (o_s_cs !== 1'b1 || o_s_we !== 1'b1 || o_s_addr !== 16'h8000 || o_s_dat !== 16'h1234)
            begin bad++; $display("FAIL wr_bus[%0d] cs/we/addr/dat got=%0b/%0b/%h/%h want=1/1/8000/1234", k, o_s_cs, o_s_we, o_s_addr, o_s_dat); end
         total++; if (o_m1_ack !== 1'(k == 2) || o_m0_ack !== 1'b0)
            begin bad++; $display("FAIL wr_ack[%0d] ack1/ack0 got=%0b/%0b want=%0d/0", k, o_m1_ack, o_m0_ack, k == 2); end
      end
      tick(); idle_inputs();
   endtask

   task automatic test_timeout(input bit real_ack);
      do_reset();
      i_m0_cs = 1; i_m0_addr = 16'h0300; i_s_dat = 16'hDEAD;
      for (int k = 0; k < 4; k++) begin
         tick();
         if (k == 3 && real_ack) begin i_s_ack = 1; i_s_dat = 16'h5A5A; end
         settle();
         if (k < 3) begin
            total++; if (o_s_cs !== 1'b1 || o_m0_ack !== 1'b0 || o_err !== 1'b0)
               begin bad++; $display("FAIL tmo_wait[%0d] cs/ack/err got=%0b/%0b/%0b want=1/0/0", k, o_s_cs, o_m0_ack, o_err); end
         end else if (!real_ack) begin
            total++; if (o_m0_ack !== 1'b1 || o_m0_dat !== 16'h0000 || o_err !== 1'b1 || o_s_cs !== 1'b0)
               begin bad++; $display("FAIL tmo_fire ack/dat/err/cs got=%0b/%h/%0b/%0b want=1/0000/1/0", o_m0_ack, o_m0_dat, o_err, o_s_cs); end
         end else begin
            total++; if (o_m0_ack !== 1'b1 || o_m0_dat !== 16'h5A5A || o_err !== 1'b0)
               begin bad++; $display("FAIL tmo_real ack/dat/err got=%0b/%h/%0b want=1/5a5a/0", o_m0_ack, o_m0_dat, o_err); end
         end
      end
      tick(); idle_inputs(); settle();
      total++; if (o_s_cs !== 1'b0 || o_err !== 1'b0)
         begin bad++; $display("FAIL tmo_idle cs/err got=%0b/%0b want=0/0", o_s_cs, o_err); end
   endtask

   task automatic test_abort();
      do_reset();
      i_m1_cs = 1; i_m1_addr = 16'h0400;
      tick(); settle();
      total++; if (o_s_cs !== 1'b1 || o_grant !== 1'b1)
         begin bad++; $display("FAIL ab_grant cs/grant got=%0b/%0b want=1/1", o_s_cs, o_grant); end
      tick(); i_m1_cs = 0; settle();
      total++; if (o_s_cs !== 1'b0 || o_m1_ack !== 1'b0)
         begin bad++; $display("FAIL ab_drop cs/ack1 got=%0b/%0b want=0/0", o_s_cs, o_m1_ack); end
      tick(); i_m0_cs = 1; i_m0_addr = 16'h0042; settle();
      total++; if (o_s_cs !== 1'b0) begin bad++; $display("FAIL ab_idle cs got=%0b want=0", o_s_cs); end
      tick(); i_s_ack = 1; i_s_dat = 16'h0C0C; settle();
      total++; if (o_s_cs !== 1'b1 || o_grant !== 1'b0 || o_s_addr !== 16'h0042 || o_m0_ack !== 1'b1)
         begin bad++; $display("FAIL ab_m0 cs/grant/addr/ack got=%0b/%0b/%h/%0b want=1/0/0042/1", o_s_cs, o_grant, o_s_addr, o_m0_ack); end
      tick(); idle_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      i_m0_cs = 1; i_m0_addr = 16'h0500;
      tick(); settle();
      total++; if (o_s_cs !== 1'b1) begin bad++; $display("FAIL rm_busy cs got=%0b want=1", o_s_cs); end
      tick(); i_reset = 1;
      tick(); i_s_ack = 1; settle();
      total++; if (o_s_cs !== 1'b0 || o_m0_ack !== 1'b0)
         begin bad++; $display("FAIL rm_drop cs/ack got=%0b/%0b want=0/0", o_s_cs, o_m0_ack); end
      tick(); i_reset = 0; i_s_ack = 0; settle();
      total++; if (o_s_cs !== 1'b0) begin bad++; $display("FAIL rm_idle cs got=%0b want=0", o_s_cs); end
      tick(); i_s_ack = 1; i_s_dat = 16'h7777; settle();
      total++; if (o_s_cs !== 1'b1 || o_m0_ack !== 1'b1 || o_m0_dat !== 16'h7777)
         begin bad++; $display("FAIL rm_serve cs/ack/dat got=%0b/%0b/%h want=1/1/7777", o_s_cs, o_m0_ack, o_m0_dat); end
      tick(); idle_inputs();
   endtask

   task automatic test_random(input int n);
      bit done0, done1;
      done0 = 0; done1 = 0;
      do_reset();
      for (int c = 0; c < n; c++) begin
         if (done0 || (i_m0_cs && $urandom_range(99) < 3)) i_m0_cs = 0;
         if (!i_m0_cs && $urandom_range(99) < 40) begin
            i_m0_cs = 1; i_m0_we = 1'($urandom); i_m0_addr = 16'($urandom); i_m0_dat = 16'($urandom);
         end
         if (done1 || (i_m1_cs && $urandom_range(99) < 3)) i_m1_cs = 0;
         if (!i_m1_cs && $urandom_range(99) < 40) begin
            i_m1_cs = 1; i_m1_we = 1'($urandom); i_m1_addr = 16'($urandom); i_m1_dat = 16'($urandom);
         end
         i_s_ack = ($urandom_range(99) < 25);
         i_s_dat = 16'($urandom);
         i_reset = ($urandom_range(199) == 0);
         settle();
         total++; if ({o_s_cs, o_s_we, o_s_addr, o_s_dat} !== {exp_s_cs, exp_s_we, exp_s_addr, exp_s_dat})
            begin bad++; $display("FAIL rnd_slave[%0d] cs/we/addr/dat got=%0b/%0b/%h/%h want=%0b/%0b/%h/%h", c, o_s_cs, o_s_we, o_s_addr, o_s_dat, exp_s_cs, exp_s_we, exp_s_addr, exp_s_dat); end
         total++; if ({o_m0_ack, o_m1_ack, o_err} !== {exp_ack0, exp_ack1, exp_err})
            begin bad++; $display("FAIL rnd_ack[%0d] ack0/ack1/err got=%0b/%0b/%0b want=%0b/%0b/%0b", c, o_m0_ack, o_m1_ack, o_err, exp_ack0, exp_ack1, exp_err); end
         if (exp_ack0) begin
            total++; if (o_m0_dat !== exp_rdat) begin bad++; $display("FAIL rnd_dat0[%0d] got=%h want=%h", c, o_m0_dat, exp_rdat); end
         end
         if (exp_ack1) begin
            total++; if (o_m1_dat !== exp_rdat) begin bad++; $display("FAIL rnd_dat1[%0d] got=%h want=%h", c, o_m1_dat, exp_rdat); end
         end
         if (exp_s_cs) begin
            total++; if (o_grant !== 1'(m_owner)) begin bad++; $display("FAIL rnd_grant[%0d] got=%0b want=%0d", c, o_grant, m_owner); end
         end
         done0 = exp_ack0;
         done1 = exp_ack1;
         tick();
      end
      i_reset = 0;
      idle_inputs();
      tick();
   endtask

   initial begin
      i_reset = 1'b1;
      idle_inputs();
      test_reset();
      test_single_read();
      test_round_robin();
      test_write();
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_abort();
      test_reset_mid();
      test_random(1500);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Two-master, one-slave arbiter for the 16-bit CPU memory bus (addr/dat/ack/we/cs).
- Lets a second requester (DMA/loader/debug port) share system memory with the CPU core.
- Round-robin grant, held for one transaction until slave ack.
- Bus-timeout watchdog synthesises an error ack so a dead slave cannot hang a master.

Parameters:
TIMEOUT, 64, cycles in BUSY without slave ack before forced completion; 0 disables the watchdog
TMO_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2**TMO_W
M0_FIRST, 1, which master wins the first arbitration after reset (1 = m0/CPU, 0 = m1)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_m0_addr  in  16  master 0 (CPU) address
i_m0_dat  in  16  master 0 write data
i_m0_we  in  1  master 0 write enable
i_m0_cs  in  1  master 0 request; held until ack
o_m0_dat  out  16  read data to master 0
o_m0_ack  out  1  ack to master 0
i_m1_addr  in  16  master 1 address
i_m1_dat  in  16  master 1 write data
i_m1_we  in  1  master 1 write enable
i_m1_cs  in  1  master 1 request
o_m1_dat  out  16  read data to master 1
o_m1_ack  out  1  ack to master 1
o_s_addr  out  16  slave address
o_s_dat  out  16  slave write data
o_s_we  out  1  slave write enable
o_s_cs  out  1  slave chip select
i_s_dat  in  16  slave read data
i_s_ack  in  1  slave ack
o_err  out  1  one-cycle pulse on timeout completion
o_grant  out  1  current owner: 0 = m0, 1 = m1; valid in BUSY

Behaviour:
- Reset is synchronous on i_reset; clock is i_clk.
- Reset values:
  - state = IDLE, counter = 0, o_err = 0.
  - Last-served pointer set so the M0_FIRST master wins the first tie.
  - o_s_cs = 0, o_s_we = 0, o_s_addr = 0, o_s_dat = 0, o_m*_ack = 0.
- States: IDLE, BUSY.
- IDLE:
  - Slave outputs are all zero.
  - If exactly one master has cs = 1, register it as grant and go to BUSY.
  - If both request, grant the master not served last (round-robin).
  - Arbitration latency: 1 cycle from cs to o_s_cs.
- BUSY:
  - Slave addr/dat/we/cs are driven combinationally from the granted master.
  - o_mX_ack = i_s_ack only for the granted master; the other master's ack = 0.
  - o_m0_dat = o_m1_dat = i_s_dat (read data broadcast; only the ack qualifies it).
  - On i_s_ack: record last-served = grant, return to IDLE next cycle.
- Back-to-back requests: a master holding cs across consecutive transactions (CPU fetch followed by execute memory access) gets one IDLE bubble cycle between them. The other master wins that IDLE if it is requesting.
- Abort: granted master drops cs while BUSY (e.g. its own reset) → next cycle IDLE, o_s_cs = 0, no ack delivered, last-served not updated.
- Timeout:
  - Counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - With TIMEOUT ≠ 0, when counter == TIMEOUT-1 and i_s_ack = 0:
    - Force ack to the granted master with o_mX_dat = 16'h0000.
    - o_err = 1 for that cycle, o_s_cs = 0 that cycle.
    - Go to IDLE and update last-served.
  - Real ack in the same cycle as expiry: the real ack wins, with real data and no o_err.
- i_reset asserted mid-transaction: immediate return to reset values; any pending transaction is dropped without ack.
- No combinational path from i_mX_cs to o_s_cs. The ack/data path from slave to master is combinational.

Decomposition:
- Shared package dbus_pkg:
  - State encoding (ST_IDLE = 0, ST_BUSY = 1).
  - Master index constants (M_CPU = 0, M_EXT = 1).
  - Bus width constant BUS_W = 16.
- Sub-module dbus_rr_pick: combinational 2-way round-robin selector (req[1:0], last → grant, valid). Reused when the master count grows.

Test Plan:
- Only m0 requests a read of 0x0010; slave acks 2 cycles after o_s_cs with 0xBEEF → o_s_cs rises 1 cycle after i_m0_cs; o_m0_ack pulses with o_m0_dat = 0xBEEF; o_m1_ack stays 0.
- Both request simultaneously after reset (M0_FIRST = 1), slave acks immediately each time → service order m0, m1, m0, m1; each grant is separated by one IDLE cycle.
- m1 writes 0x1234 to 0x8000 while m0 is idle → o_s_we = 1, o_s_addr = 0x8000, o_s_dat = 0x1234 for the whole BUSY window; o_m1_ack on slave ack.
- TIMEOUT = 4, slave never acks m0 → ack + o_err at the 4th BUSY cycle, o_m0_dat = 0x0000, state IDLE next cycle.
- Slave ack coincides with timeout expiry → normal ack with real data, o_err = 0.
- m1 drops cs in its second BUSY cycle; separately, i_reset asserted mid-BUSY → o_s_cs = 0 next cycle, no ack issued, m0 then served normally.
